// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux (branch > jump > sequential > hold) and the PC+4 adder.
module fetch_next_pc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             pc_src,
  input  logic [WIDTH-1:0] pc_branch,
  input  logic             jump,
  input  logic [WIDTH-1:0] pc_jump,
  input  logic             advance,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc_next,
  output logic             redirect
);

  assign pc_plus4 = pc + WIDTH'(4);
  assign redirect = pc_src | jump;

  always_comb begin
    pc_next = pc;
    if (pc_src) begin
      pc_next = pc_branch;
    end else if (jump) begin
      pc_next = pc_jump;
    end else if (advance) begin
      pc_next = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, imem req/ack handshake.
// Optional FETCH_PERF_EN adds saturating busy-cycle and redirect counters.
//
// state | meaning
// IDLE  | first cycle after reset release, no request
// FETCH | request to PCF outstanding, delivers on ack
// HOLD  | stalled with a buffered instruction
// DRAIN | waiting for the ack of an abandoned request
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             StallF,
  input  logic             PCSrcD,
  input  logic [WIDTH-1:0] PCBranchD,
  input  logic             JumpD,
  input  logic [WIDTH-1:0] PCJumpD,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_ack,
  output logic [WIDTH-1:0] InstrF,
  output logic [WIDTH-1:0] PCPlus4F,
  output logic [WIDTH-1:0] PCF,
`ifdef FETCH_PERF_EN
  output logic [31:0]      PerfBusyCnt,
  output logic [31:0]      PerfRedirCnt,
`endif
  output logic             FetchBusyF
);

  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             req_q, req_d;

  logic             ack_fetch;
  logic             deliver;
  logic             redirect;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] pc_next;

  assign ack_fetch = (state_q == ST_FETCH) && imem_ack;
  assign deliver   = ack_fetch || (state_q == ST_HOLD);

  fetch_next_pc #(
    .WIDTH(WIDTH)
  ) u_next_pc (
    .pc        (pc_q),
    .pc_src    (PCSrcD),
    .pc_branch (PCBranchD),
    .jump      (JumpD),
    .pc_jump   (PCJumpD),
    .advance   (deliver),
    .pc_plus4  (pc_plus4),
    .pc_next   (pc_next),
    .redirect  (redirect)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (!StallF) pc_d = pc_next;
      end
      ST_FETCH: begin
        addr_d = pc_q;
        if (imem_ack) begin
          if (StallF) begin
            hold_d  = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            pc_d = pc_next;
          end
        end else if (!StallF && redirect) begin
          // Request stays in flight; its response must be swallowed in DRAIN.
          pc_d    = pc_next;
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (!StallF) begin
          pc_d    = pc_next;
          hold_d  = NOP_W;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (!StallF) pc_d = pc_next;
        if (imem_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_FETCH);
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_W;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  // addr_q keeps the abandoned request's address visible while draining.
  assign imem_req   = req_q;
  assign imem_addr  = (state_q == ST_FETCH) ? pc_q : addr_q;
  assign PCF        = pc_q;
  assign InstrF     = ack_fetch ? imem_rdata : ((state_q == ST_HOLD) ? hold_q : NOP_W);
  assign PCPlus4F   = deliver ? pc_plus4 : '0;
  assign FetchBusyF = !deliver;

`ifdef FETCH_PERF_EN
  logic [31:0] busy_cnt_q, busy_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    busy_cnt_d  = busy_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (FetchBusyF && (busy_cnt_q != '1)) busy_cnt_d = busy_cnt_q + 32'd1;
    if (!StallF && redirect && (redir_cnt_q != '1)) redir_cnt_d = redir_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      busy_cnt_q  <= '0;
      redir_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign PerfBusyCnt  = busy_cnt_q;
  assign PerfRedirCnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a behavioural variable-latency instruction memory.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0, PCSrcD = 1'b0, JumpD = 1'b0;
  logic [31:0] PCBranchD = '0, PCJumpD = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] InstrF, PCPlus4F, PCF;
  logic        FetchBusyF;
`ifdef FETCH_PERF_EN
  logic [31:0] PerfBusyCnt, PerfRedirCnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // memory model controls and state
  bit          mem_auto = 1'b1;
  bit          mem_fast = 1'b1;
  int          mem_wait = 1;
  logic        manual_ack = 1'b0;
  logic [31:0] manual_data = '0;
  bit          active = 1'b0;
  int          cnt = 0, target = 0;
  logic [31:0] lat_addr = '0;
  logic        was_ack;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .rst(rst), .StallF(StallF), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .JumpD(JumpD), .PCJumpD(PCJumpD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .PCF(PCF),
`ifdef FETCH_PERF_EN
    .PerfBusyCnt(PerfBusyCnt), .PerfRedirCnt(PerfRedirCnt),
`endif
    .FetchBusyF(FetchBusyF)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h1234};
  endfunction

  // Fast mode: first access waits one cycle, back-to-back accesses ack at once.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      was_ack = imem_ack;
      if (!mem_auto || !rst) begin
        active     = 1'b0;
        imem_ack   = mem_auto ? 1'b0 : manual_ack;
        imem_rdata = manual_data;
      end else begin
        if (was_ack) active = 1'b0;
        if (!active && imem_req) begin
          active   = 1'b1;
          cnt      = 0;
          lat_addr = imem_addr;
          target   = (mem_fast && was_ack) ? 0 : mem_wait;
        end else if (active) begin
          cnt++;
        end
        imem_ack   = active && (cnt == target);
        imem_rdata = imem_ack ? mem_word(lat_addr) : 32'hDEAD_BEEF;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #3;
  endtask

  task automatic do_reset();
    StallF = 0; PCSrcD = 0; JumpD = 0; PCBranchD = '0; PCJumpD = '0;
    mem_auto = 1; manual_ack = 0; exp_q.delete();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    step();
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    checks++; if (InstrF !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", InstrF); end
    checks++; if (PCPlus4F !== 32'h0) begin errors++; $display("FAIL reset_pcplus4 got=%h exp=0", PCPlus4F); end
    checks++; if (FetchBusyF !== 1'b1) begin errors++; $display("FAIL reset_busy got=%0b exp=1", FetchBusyF); end
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", PCF); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%0b exp=0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got=%0b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_zero_wait();
    int cyc = 0, first = -1, busy_after = 0;
    logic [31:0] pe;
    do_reset();
    mem_fast = 1; mem_wait = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    while (exp_q.size() > 0 && cyc < 30) begin
      step();
      cyc++;
      if (!FetchBusyF) begin
        pe = exp_q.pop_front();
        if (first < 0) first = cyc;
        checks++; if (PCF !== pe) begin errors++; $display("FAIL zw_pc got=%h exp=%h", PCF, pe); end
        checks++; if (InstrF !== mem_word(pe)) begin errors++; $display("FAIL zw_instr got=%h exp=%h", InstrF, mem_word(pe)); end
        checks++; if (PCPlus4F !== pe + 32'd4) begin errors++; $display("FAIL zw_pcplus4 got=%h exp=%h", PCPlus4F, pe + 32'd4); end
      end else if (first >= 0) begin
        busy_after++;
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zw_timeout left=%0d exp=0", exp_q.size()); end
    checks++; if (first != 2) begin errors++; $display("FAIL zw_first_cycle got=%0d exp=2", first); end
    checks++; if (busy_after != 0) begin errors++; $display("FAIL zw_busy_after got=%0d exp=0", busy_after); end
  endtask

  task automatic test_latency3();
    int cyc = 0, run = 0;
    logic [31:0] pe;
    do_reset();
    mem_fast = 0; mem_wait = 2;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    while (exp_q.size() > 0 && cyc < 40) begin
      step();
      cyc++;
      if (imem_req) begin
        checks++; if (imem_addr !== exp_q[0]) begin errors++; $display("FAIL lat_addr_stable got=%h exp=%h", imem_addr, exp_q[0]); end
      end
      if (!FetchBusyF) begin
        pe = exp_q.pop_front();
        checks++; if (PCF !== pe) begin errors++; $display("FAIL lat_pc got=%h exp=%h", PCF, pe); end
        checks++; if (InstrF !== mem_word(pe)) begin errors++; $display("FAIL lat_instr got=%h exp=%h", InstrF, mem_word(pe)); end
        checks++; if (run != 2) begin errors++; $display("FAIL lat_busy_run got=%0d exp=2", run); end
        run = 0;
      end else if (imem_req) begin
        run++;
        checks++; if (InstrF !== 32'h0 || PCPlus4F !== 32'h0) begin errors++; $display("FAIL lat_bubble got=%h/%h exp=0/0", InstrF, PCPlus4F); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lat_timeout left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_stall_hold();
    int n = 0;
    do_reset();
    mem_fast = 1; mem_wait = 1;
    while (!(PCF == 32'h8 && !FetchBusyF) && n < 20) begin step(); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL hold_reach_pc8 got=timeout exp=delivery of 8"); end
    StallF = 1;
    step();
    checks++; if (InstrF !== mem_word(32'h8)) begin errors++; $display("FAIL hold_instr got=%h exp=%h", InstrF, mem_word(32'h8)); end
    checks++; if (PCF !== 32'h8) begin errors++; $display("FAIL hold_pc got=%h exp=8", PCF); end
    checks++; if (PCPlus4F !== 32'hC) begin errors++; $display("FAIL hold_pcplus4 got=%h exp=c", PCPlus4F); end
    checks++; if (FetchBusyF !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL hold_busy_req got=%0b/%0b exp=0/0", FetchBusyF, imem_req); end
    step();
    checks++; if (InstrF !== mem_word(32'h8) || PCF !== 32'h8) begin errors++; $display("FAIL hold_persist got=%h/%h exp=%h/8", InstrF, PCF, mem_word(32'h8)); end
    StallF = 0;
    step();
    checks++; if (PCF !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL hold_release got=%h/%0b/%h exp=c/1/c", PCF, imem_req, imem_addr); end
    step();
    checks++; if (FetchBusyF !== 1'b0 || InstrF !== mem_word(32'hC)) begin errors++; $display("FAIL hold_next_instr got=%0b/%h exp=0/%h", FetchBusyF, InstrF, mem_word(32'hC)); end
  endtask

  task automatic test_branch_drain();
    int n = 0;
    do_reset();
    mem_fast = 0; mem_wait = 2;
    while (!(imem_req && imem_addr == 32'h10 && !imem_ack) && n < 40) begin step(); n++; end
    checks++; if (n >= 40) begin errors++; $display("FAIL drain_reach_10 got=timeout exp=request to 10"); end
    PCSrcD = 1; PCBranchD = 32'h40;
    step();
    PCSrcD = 0; PCBranchD = '0;
    checks++; if (imem_req !== 1'b0 || PCF !== 32'h40) begin errors++; $display("FAIL drain_enter got=%0b/%h exp=0/40", imem_req, PCF); end
    checks++; if (imem_addr !== 32'h10 || FetchBusyF !== 1'b1) begin errors++; $display("FAIL drain_addr_busy got=%h/%0b exp=10/1", imem_addr, FetchBusyF); end
    step();
    checks++; if (FetchBusyF !== 1'b1 || InstrF !== 32'h0) begin errors++; $display("FAIL drain_discard got=%0b/%h exp=1/0", FetchBusyF, InstrF); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL drain_refetch got=%0b/%h exp=1/40", imem_req, imem_addr); end
    n = 0;
    while (FetchBusyF && n < 10) begin step(); n++; end
    checks++; if (PCF !== 32'h40 || InstrF !== mem_word(32'h40)) begin errors++; $display("FAIL drain_target_instr got=%h/%h exp=40/%h", PCF, InstrF, mem_word(32'h40)); end
    checks++; if (PCPlus4F !== 32'h44) begin errors++; $display("FAIL drain_pcplus4 got=%h exp=44", PCPlus4F); end
  endtask

  task automatic test_priority();
    int n = 0;
    do_reset();
    mem_fast = 1; mem_wait = 1;
    while (FetchBusyF && n < 10) begin step(); n++; end
    PCSrcD = 1; PCBranchD = 32'h40; JumpD = 1; PCJumpD = 32'h80;
    step();
    checks++; if (PCF !== 32'h40 || imem_addr !== 32'h40) begin errors++; $display("FAIL prio_branch_wins got=%h/%h exp=40/40", PCF, imem_addr); end
    PCSrcD = 1; PCBranchD = 32'h100; JumpD = 0; PCJumpD = '0; StallF = 1;
    step();
    checks++; if (PCF !== 32'h40 || InstrF !== mem_word(32'h40)) begin errors++; $display("FAIL prio_stall_freeze got=%h/%h exp=40/%h", PCF, InstrF, mem_word(32'h40)); end
    step();
    checks++; if (PCF !== 32'h40) begin errors++; $display("FAIL prio_stall_freeze2 got=%h exp=40", PCF); end
    StallF = 0;
    step();
    PCSrcD = 0; PCBranchD = '0;
    checks++; if (PCF !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL prio_hold_redirect got=%h/%0b exp=100/1", PCF, imem_req); end
    n = 0;
    while (FetchBusyF && n < 10) begin step(); n++; end
    JumpD = 1; PCJumpD = 32'hFFFF_FFFC;
    step();
    JumpD = 0; PCJumpD = '0;
    checks++; if (PCF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jump_target got=%h exp=fffffffc", PCF); end
    n = 0;
    while (FetchBusyF && n < 10) begin step(); n++; end
    checks++; if (PCPlus4F !== 32'h0 || InstrF !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_pcplus4 got=%h/%h exp=0/%h", PCPlus4F, InstrF, mem_word(32'hFFFF_FFFC)); end
    step();
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", PCF); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_auto = 0; manual_ack = 0;
    step();
    manual_ack = 1; manual_data = 32'h1234_5678;
    step();
    manual_ack = 0;
    checks++; if (InstrF !== 32'h1234_5678 || FetchBusyF !== 1'b0) begin errors++; $display("FAIL rm_deliver got=%h/%0b exp=12345678/0", InstrF, FetchBusyF); end
    step();
    checks++; if (PCF !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL rm_outstanding got=%h/%0b/%h exp=4/1/4", PCF, imem_req, imem_addr); end
    #1 rst = 1'b0;
    #1;
    checks++; if (PCF !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rm_async_pc_req got=%h/%0b exp=0/0", PCF, imem_req); end
    checks++; if (FetchBusyF !== 1'b1 || InstrF !== 32'h0 || PCPlus4F !== 32'h0) begin errors++; $display("FAIL rm_async_outs got=%0b/%h/%h exp=1/0/0", FetchBusyF, InstrF, PCPlus4F); end
    manual_ack = 1; manual_data = 32'hBAD0_0BAD;
    step();
    rst = 1'b1;
    manual_ack = 0;
    #1;
    checks++; if (FetchBusyF !== 1'b1 || InstrF !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rm_late_ack got=%0b/%h/%0b exp=1/0/0", FetchBusyF, InstrF, imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || PCF !== 32'h0) begin errors++; $display("FAIL rm_restart got=%0b/%h/%h exp=1/0/0", imem_req, imem_addr, PCF); end
    mem_auto = 1;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency3();
    test_stall_hold();
    test_branch_drain();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
